// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, one-hot result codes, chunk count.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_e;

  // Result bit order is {lt, eq, gt}
  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_comparator.sv
// Combinational CHUNK-bit unsigned magnitude compare; zero latency, no flow control.
module chunk_comparator #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// MSB-first multi-cycle comparator, CHUNK bits/cycle, valid/ready in and out; result held until out_ready.
// SEQ_CMP_EARLY_EXIT_EN: stop at the first unequal chunk (1..NCHUNK cycles); otherwise always NCHUNK cycles.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  cmp_state_e       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sign_mask;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_lt, c_eq, c_gt;
  logic [2:0]       chunk_res;
`ifndef SEQ_CMP_EARLY_EXIT_EN
  logic             found_q;
  logic [2:0]       res_q;
`endif

  assign in_ready = (state == IDLE);

  // Flipping both MSBs maps two's-complement order onto unsigned order
  assign sign_mask = signed_mode ? MSB_MASK : '0;

  assign a_chunk = a_q[int'(idx) * CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(idx) * CHUNK +: CHUNK];

  chunk_comparator #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a  (a_chunk),
    .b  (b_chunk),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  assign chunk_res = c_lt ? CMP_LT : (c_gt ? CMP_GT : CMP_EQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      out_valid   <= 1'b0;
      {lt, eq, gt} <= 3'b000;
`ifndef SEQ_CMP_EARLY_EXIT_EN
      found_q     <= 1'b0;
      res_q       <= CMP_EQ;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a ^ sign_mask;
            b_q   <= b ^ sign_mask;
            idx   <= IDX_W'(NCHUNK - 1);
            state <= RUN;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            found_q <= 1'b0;
            res_q   <= CMP_EQ;
`endif
          end
        end
        RUN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
          if (!c_eq || idx == '0) begin
            {lt, eq, gt} <= chunk_res;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          // The first unequal chunk decides; later chunks are walked only for fixed latency
          if (!found_q && !c_eq) begin
            found_q <= 1'b1;
            res_q   <= chunk_res;
          end
          if (idx == '0) begin
            {lt, eq, gt} <= found_q ? res_q : chunk_res;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            {lt, eq, gt} <= 3'b000;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=32, CHUNK=4); latency expectations follow SEQ_CMP_EARLY_EXIT_EN.
module tb_seq_magnitude_comparator;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = 8;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             lt, eq, gt;

  int checks   = 0;
  int failures = 0;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        sm;
    logic [2:0]  res;
    int          k;
  } vec_t;

  function automatic int exp_lat(input int k_early);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    return k_early;
`else
    return NCHUNK;
`endif
  endfunction

  // Present operands for one accept edge, then scramble the inputs.
  task automatic start(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    in_valid = 1'b1; a = ta; b = tb_v; signed_mode = ts;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, lt, eq, gt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", {out_valid, lt, eq, gt});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_compare();
    vec_t v[$];
    int   cyc;
    v.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, R_GT, 1});
    v.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, R_LT, 1});
    v.push_back('{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, R_EQ, 8});
    v.push_back('{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, R_EQ, 8});
    v.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, R_GT, 8});
    v.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, R_LT, 1});
    v.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, R_GT, 1});
    v.push_back('{32'h1230_0000, 32'h1240_0000, 1'b0, R_LT, 3});
    v.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, R_LT, 8});
    foreach (v[i]) begin
      start(v[i].va, v[i].vb, v[i].sm);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL cmp%0d_busy in_ready=%b want=0", i, in_ready);
      end
      wait_out(cyc);
      checks++;
      if (cyc !== exp_lat(v[i].k)) begin
        failures++;
        $display("FAIL cmp%0d_latency got=%0d want=%0d", i, cyc, exp_lat(v[i].k));
      end
      checks++;
      if ({lt, eq, gt} !== v[i].res) begin
        failures++;
        $display("FAIL cmp%0d_result got=%b want=%b", i, {lt, eq, gt}, v[i].res);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if ({out_valid, lt, eq, gt, in_ready} !== 5'b00001) begin
        failures++;
        $display("FAIL cmp%0d_release got=%b want=00001", i, {out_valid, lt, eq, gt, in_ready});
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    start(32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_out(cyc);
    in_valid = 1'b1; a = 32'h0000_0001; b = 32'h0000_0002; signed_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, lt, eq, gt, in_ready} !== 5'b10010) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b want=10010", i, {out_valid, lt, eq, gt, in_ready});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_idle got=%b want=01", {out_valid, in_ready});
    end
    // in_valid still high: this edge accepts the waiting operands
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept in_ready=%b want=0", in_ready);
    end
    wait_out(cyc);
    checks++;
    if (cyc !== NCHUNK) begin
      failures++;
      $display("FAIL bp_latency got=%0d want=%0d", cyc, NCHUNK);
    end
    checks++;
    if ({lt, eq, gt} !== R_LT) begin
      failures++;
      $display("FAIL bp_result got=%b want=%b", {lt, eq, gt}, R_LT);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start(32'h1111_1111, 32'h1111_1111, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, lt, eq, gt, in_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL rst_mid got=%b want=00001", {out_valid, lt, eq, gt, in_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_after got=%b want=01", {out_valid, in_ready});
    end
    start(32'h0000_0003, 32'h0000_0005, 1'b0);
    wait_out(cyc);
    checks++;
    if (cyc !== NCHUNK) begin
      failures++;
      $display("FAIL rst_fresh_latency got=%0d want=%0d", cyc, NCHUNK);
    end
    checks++;
    if ({lt, eq, gt} !== R_LT) begin
      failures++;
      $display("FAIL rst_fresh_result got=%b want=%b", {lt, eq, gt}, R_LT);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_compare();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands, evaluated MSB-first, CHUNK bits per clock. It replaces the fixed 8-bit combinational comparator wherever wide operands would otherwise create long compare chains. Inputs and outputs use valid/ready handshakes. A per-transaction mode selects unsigned or two's-complement comparison.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK and at least CHUNK.
CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
lt  output  1  A < B
eq  output  1  A == B
gt  output  1  A > B

Behaviour:
- Reset: state IDLE; out_valid=0; lt=eq=gt=0; internal operand registers and chunk index cleared. Reset takes effect immediately at any point, including mid-RUN or in DONE. The in-flight transaction is discarded.
- in_ready = (state==IDLE), combinational from state. Handshakes that coincide with rst high are ignored.
- FSM:
  - IDLE: on in_valid&in_ready, register a and b, idx=NCHUNK-1, then go to RUN. When signed_mode=1, the MSB of both registered operands is inverted at capture, so the compare that follows is unsigned.
  - RUN, one chunk per cycle:
    - a_chunk[idx] < b_chunk[idx]: result LT, go to DONE.
    - a_chunk[idx] > b_chunk[idx]: result GT, go to DONE.
    - chunks equal and idx==0: result EQ, go to DONE.
    - otherwise: idx decrements.
  - DONE: out_valid=1; lt/eq/gt hold a one-hot result that stays stable while out_ready=0. On out_valid&out_ready, go to IDLE and clear lt/eq/gt/out_valid on that edge.
- Latency: accept at edge 0. out_valid rises after edge k, where k = 1 + (number of equal leading chunks), with 1 <= k <= NCHUNK.
- Throughput: no overlap; the next accept is possible one cycle after the result handshake.
- Inputs a/b/signed_mode are sampled only at accept; changes afterwards have no effect.
- lt/eq/gt are registered outputs and are never asserted while out_valid=0.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: early termination as described above; variable latency, k from 1 to NCHUNK.
- Undefined: the first non-equal chunk latches the result, but RUN continues down to idx==0. out_valid always rises exactly NCHUNK cycles after accept. This gives constant latency for timing-sensitive consumers, and the results are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - state enum cmp_state_e {IDLE, RUN, DONE};
  - result encoding constants CMP_LT/CMP_EQ/CMP_GT (one-hot 3-bit);
  - helper localparam for NCHUNK.
- Sub-module chunk_comparator: parametrised CHUNK-bit purely combinational comparator with outputs lt/eq/gt. It is instantiated once and indexed by idx through a mux.

Test Plan (WIDTH=32, CHUNK=4, early exit on unless stated):
1. Unsigned, a=0x8000_0000, b=0x7FFF_FFFF -> gt=1, lt=eq=0, out_valid after 1 cycle. With macro off: after 8 cycles, same result.
2. signed_mode=1 with the same operands -> lt=1 after 1 cycle (negative vs positive).
3. a=b=0xDEAD_BEEF, both modes -> eq=1 after 8 cycles.
4. Unsigned, a=0x0000_0001, b=0x0000_0000 -> gt=1 after 8 cycles. Signed, a=0xFFFF_FFFF, b=0x0000_0000 -> lt=1 after 1 cycle.
5. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> out_valid and result held stable, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE next cycle; the following accept uses the new operands.
6. Assert rst for 1 cycle mid-RUN (idx=4) -> out_valid=0, lt=eq=gt=0, in_ready=1 immediately. A fresh transaction a=3, b=5 then yields lt=1 after 8 cycles.
